// File: rtl/dsp_hb_supervisor.sv
// -----------------------------------------------------------------------------
// dsp_hb_supervisor
//
// Heartbeat supervisor for N_CH DSPs that share the external bus (XZCS6 zone).
// Each DSP must write to its own heartbeat address (HB_BASE + channel) at
// regular intervals. When the heartbeats stop, the channel raises a fault and
// drives a timed reset pulse to its DSP. A re-init window follows the pulse.
// After MAX_RETRY failed recoveries the channel locks out until software
// clears it with i_clr_lock. A global XINT flag, set and cleared by bus
// writes, is merged into XINT_DSP_ERR.
//
// Ports
//   clk_20M       system clock (20 MHz)
//   reset_n       asynchronous active-low reset, synchronous release upstream
//   XZCS6, XWE    DSP zone-6 chip select and write enable (active low, async)
//   DSP_A         DSP address bus (async)
//   i_wd_err      per-channel external watchdog fault, overrides this block
//   i_clr_lock    per-channel lockout clear pulse
//   o_dsp_rst     per-channel DSP reset drive (active high)
//   o_ch_fault    per-channel fault flag
//   o_lock        per-channel lockout flag
//   o_retry       per-channel retry count, channel k in [4k+3:4k]
//   XINT_DSP_ERR  XINT flag OR any channel fault
//   dbg_state     per-channel FSM state, channel k in [2k+1:2k]
//                 (0 MON, 1 RST, 2 INIT, 3 LOCK)
// -----------------------------------------------------------------------------
module dsp_hb_supervisor #(
   parameter int                N_CH      = 2,
   parameter int                ADDR_W    = 16,
   parameter logic [ADDR_W-1:0] HB_BASE   = 16'h0350,
   parameter logic [ADDR_W-1:0] XINT_SET  = 16'h035A,
   parameter logic [ADDR_W-1:0] XINT_CLR  = 16'h03A5,
   parameter int                TICK_DIV  = 100,
   parameter int                T_ERR     = 600,
   parameter int                T_RST     = 200,
   parameter int                T_INIT    = 20000,
   parameter int                MAX_RETRY = 3
) (
   input  logic                clk_20M,
   input  logic                reset_n,
   input  logic                XZCS6,
   input  logic                XWE,
   input  logic [ADDR_W-1:0]   DSP_A,
   input  logic [N_CH-1:0]     i_wd_err,
   input  logic [N_CH-1:0]     i_clr_lock,
   output logic [N_CH-1:0]     o_dsp_rst,
   output logic [N_CH-1:0]     o_ch_fault,
   output logic [N_CH-1:0]     o_lock,
   output logic [4*N_CH-1:0]   o_retry,
   output logic                XINT_DSP_ERR,
   output logic [2*N_CH-1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_MON  = 2'd0,
      ST_RST  = 2'd1,
      ST_INIT = 2'd2,
      ST_LOCK = 2'd3
   } state_t;

   // Match vector layout: [N_CH-1:0] heartbeats, [N_CH] XINT set, [N_CH+1] XINT clear
   localparam int NM = N_CH + 2;
   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [NM-1:0] match;
   logic [NM-1:0] sync1, sync2, sync3;
   logic [NM-1:0] evt;
   logic          xint_flag;
   logic [PW-1:0] presc;
   logic          tick;

   // Address decode straight off the asynchronous bus; the synchronizer
   // below absorbs any decode glitches.
   always_comb begin
      match = '0;
      for (int k = 0; k < N_CH; k++) begin
         match[k] = (DSP_A == HB_BASE + ADDR_W'(k));
      end
      match[N_CH]   = (DSP_A == XINT_SET);
      match[N_CH+1] = (DSP_A == XINT_CLR);
      if (XZCS6 || XWE) begin
         match = '0;
      end
   end

   // Two-flop synchronizer plus an edge-detect flop, so a held write
   // gives exactly one event.
   always_ff @(posedge clk_20M or negedge reset_n) begin
      if (!reset_n) begin
         sync1 <= '0;
         sync2 <= '0;
         sync3 <= '0;
      end else begin
         sync1 <= match;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign evt = sync2 & ~sync3;

   always_ff @(posedge clk_20M or negedge reset_n) begin
      if (!reset_n) begin
         xint_flag <= 1'b0;
      end else if (evt[N_CH]) begin
         xint_flag <= 1'b1;
      end else if (evt[N_CH+1]) begin
         xint_flag <= 1'b0;
      end
   end

   // Shared prescaler: tick is high in the last count of each period.
   assign tick = (presc == PW'(TICK_DIV - 1));

   always_ff @(posedge clk_20M or negedge reset_n) begin
      if (!reset_n) begin
         presc <= '0;
      end else if (tick) begin
         presc <= '0;
      end else begin
         presc <= presc + PW'(1);
      end
   end

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      state_t      state;
      logic [15:0] cnt;
      logic [3:0]  retry;
      logic        fault_q;
      logic        rst_q;
      logic        lock_q;
      logic [15:0] lim;

      // MON and INIT share the timeout path; only the limit differs.
      assign lim = (state == ST_INIT) ? 16'(T_INIT - 1) : 16'(T_ERR - 1);

      always_ff @(posedge clk_20M or negedge reset_n) begin
         if (!reset_n) begin
            state   <= ST_MON;
            cnt     <= '0;
            retry   <= '0;
            fault_q <= 1'b0;
            rst_q   <= 1'b0;
            lock_q  <= 1'b0;
         end else if (i_wd_err[k]) begin
            // External watchdog owns the DSP; park the channel unless locked.
            if (state != ST_LOCK) begin
               state   <= ST_MON;
               cnt     <= '0;
               fault_q <= 1'b0;
               rst_q   <= 1'b0;
               lock_q  <= 1'b0;
            end
         end else begin
            case (state)
               ST_MON, ST_INIT: begin
                  if (evt[k]) begin
                     // A heartbeat beats a coincident timeout tick.
                     state   <= ST_MON;
                     cnt     <= '0;
                     fault_q <= 1'b0;
                     if (state == ST_MON) begin
                        retry <= '0;
                     end
                  end else if (tick) begin
                     if (cnt == lim) begin
                        cnt     <= '0;
                        fault_q <= 1'b1;
                        if (retry < 4'(MAX_RETRY)) begin
                           state <= ST_RST;
                           retry <= retry + 4'd1;
                           rst_q <= 1'b1;
                        end else begin
                           state  <= ST_LOCK;
                           lock_q <= 1'b1;
                           rst_q  <= 1'b0;
                        end
                     end else begin
                        cnt <= cnt + 16'd1;
                     end
                  end
               end
               ST_RST: begin
                  if (tick) begin
                     if (cnt == 16'(T_RST - 1)) begin
                        state <= ST_INIT;
                        cnt   <= '0;
                        rst_q <= 1'b0;
                     end else begin
                        cnt <= cnt + 16'd1;
                     end
                  end
               end
               ST_LOCK: begin
                  if (i_clr_lock[k]) begin
                     state   <= ST_MON;
                     cnt     <= '0;
                     fault_q <= 1'b0;
                     lock_q  <= 1'b0;
                     retry   <= '0;
                  end
               end
               default: begin
                  state <= ST_MON;
               end
            endcase
         end
      end

      assign o_dsp_rst[k]       = rst_q;
      assign o_ch_fault[k]      = fault_q;
      assign o_lock[k]          = lock_q;
      assign o_retry[4*k +: 4]  = retry;
      assign dbg_state[2*k +: 2] = state;
   end

   assign XINT_DSP_ERR = xint_flag | (|o_ch_fault);

endmodule

// File: doc/dsp_hb_supervisor.md
Name: dsp_hb_supervisor

Overview:
- Multi-channel DSP heartbeat supervisor on the DSP external bus (XZCS6 zone), clocked at 20 MHz.
- Each channel expects periodic bus writes to its own heartbeat address. If the heartbeat stops, the channel raises a fault and drives a timed reset pulse to its DSP. After the pulse, a re-init window runs.
- After MAX_RETRY failed recoveries, the channel locks out until software clears it.
- A global XINT set/clear flag is merged into the combined fault output.

Parameters:
- N_CH, 2, number of supervised channels (1..8)
- ADDR_W, 16, DSP address bus width
- HB_BASE, 16'h0350, heartbeat address of channel 0; channel k uses HB_BASE+k
- XINT_SET, 16'h035A, write to this address sets the XINT fault flag
- XINT_CLR, 16'h03A5, write to this address clears the XINT fault flag
- TICK_DIV, 100, clk_20M cycles per tick (5 us)
- T_ERR, 600, heartbeat timeout in ticks (3 ms); must be >= 2
- T_RST, 200, reset-pulse length in ticks (1 ms); must be >= 2
- T_INIT, 20000, re-init window in ticks (100 ms); must be >= 2
- MAX_RETRY, 3, reset attempts allowed before lockout (1..15)

Ports:
- clk_20M  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- XZCS6  in  1  DSP zone-6 chip select, active low, asynchronous to clk_20M
- XWE  in  1  DSP write enable, active low, asynchronous
- DSP_A  in  ADDR_W  DSP address bus, asynchronous
- i_wd_err  in  N_CH  per-channel external watchdog fault; takes precedence over this block
- i_clr_lock  in  N_CH  per-channel lockout clear, single-cycle pulse
- o_dsp_rst  out  N_CH  per-channel DSP reset drive, active high
- o_ch_fault  out  N_CH  per-channel fault flag
- o_lock  out  N_CH  per-channel lockout flag
- o_retry  out  4*N_CH  per-channel retry count, channel k in bits [4k+3:4k]
- XINT_DSP_ERR  out  1  XINT flag OR reduction of o_ch_fault

Behaviour:
- Reset (async assert, sync release): all outputs 0, all counters 0, every channel in MON, XINT flag 0.
- Bus decode (combinational): match_x = !XZCS6 & !XWE & (DSP_A==addr_x), for each HB address, XINT_SET and XINT_CLR.
  - Each match_x passes through a 2-flop synchronizer on posedge clk_20M, then a rising-edge detector.
  - Event pulse = 1 cycle, 3 cycles after the write first becomes stable.
  - A held write produces exactly one event.
- XINT flag: set by the XINT_SET event, cleared by the XINT_CLR event. The two events are mutually exclusive.
- Prescaler: free-running counter 0..TICK_DIV-1, shared by all channels. tick=1 in the cycle the count equals TICK_DIV-1, then it wraps to 0.
- Per-channel tick counter cnt: 16 bits, cleared on every state change.
- Per-channel retry counter: 4 bits, saturating at MAX_RETRY.
- FSM per channel:
  - MON: hb event clears cnt and clears retry. On tick, cnt++. On tick with cnt==T_ERR-1 (timeout):
    - if retry<MAX_RETRY: go to RST, retry++, fault=1, rst=1.
    - else: go to LOCK, fault=1, lock=1, rst=0.
  - RST: rst=1, fault=1. hb events are ignored. On tick with cnt==T_RST-1: go to INIT, rst=0.
  - INIT: fault=1. An hb event goes to MON and clears fault; retry is kept. On tick with cnt==T_INIT-1 it is a timeout, handled as in MON (RST or LOCK).
  - LOCK: fault=1, lock=1, rst=0. hb events are ignored. i_clr_lock goes to MON, clears fault, lock and retry.
- Per-channel priority: i_wd_err > i_clr_lock > hb event > tick.
  - i_wd_err=1 holds the channel in MON with cnt=0, fault=0, rst=0, lock=0. retry is unchanged.
  - Exception: a channel in LOCK stays in LOCK while i_wd_err=1.
- Simultaneous hb event and timeout tick in MON/INIT: the hb event wins, and no fault is raised.
- Timeout latency: fault/rst asserts on the first tick on which T_ERR ticks have elapsed since the last hb event. Delay from hb event to fault is between (T_ERR-1)*TICK_DIV+1 and T_ERR*TICK_DIV cycles.
- Outputs are registered, except XINT_DSP_ERR, which is a combinational OR of registered flags.
- Channels are independent. They share only the prescaler and the bus synchronizers.

Test Plan:
Bench parameters: N_CH=2, TICK_DIV=4, T_ERR=10, T_RST=3, T_INIT=20, MAX_RETRY=2.
- Channel 0 receives an HB write to 0x0350 every 30 cycles for 500 cycles -> o_ch_fault=0, o_dsp_rst=0 throughout, o_retry[3:0]=0.
- Channel 1 receives no HB after reset -> o_ch_fault[1] and o_dsp_rst[1] rise at cycle 40±4; o_dsp_rst[1] stays high 12 cycles; o_retry[7:4]=1. An HB write during INIT -> fault clears, and channel 1 returns to MON.
- Channel 0 never sends HB -> two RST pulses (retry 1, then 2). The third timeout gives LOCK with o_lock[0]=1 and o_dsp_rst[0]=0. HB writes while locked are ignored. An i_clr_lock[0] pulse -> lock=0, fault=0, retry=0.
- Write 0x035A -> XINT_DSP_ERR=1 three cycles later. Write 0x03A5 -> 0. A write to 0x035A with XZCS6=1 -> no change.
- i_wd_err[1]=1 during RST -> rst and fault drop next cycle. With i_wd_err held, no timeout occurs over 200 cycles.
- reset_n pulsed low mid-RST, asynchronously to the clock -> all outputs 0 immediately. After release, channels restart in MON with retry=0.
